multi_debounce: RTL
===================

Name: multi_debounce

Overview:
- Parametrised N-channel pushbutton/footswitch conditioner for the guitar FX board.
- Per channel: 2-FF synchroniser, counter-based debounce, and a press/long-press/auto-repeat state machine.
- Emits a debounced level plus single-cycle press, release, long-press and repeat pulses for the effect-select and parameter-edit logic.
- One shared tick prescaler times the hold durations for all channels.

Parameters:
- N_CH, 4, number of independent button channels.
- ACTIVE_LOW, 1, 1 means a pin at 0 is "pressed"; 0 means a pin at 1 is "pressed".
- DEB_CYCLES, 65536, consecutive clk cycles of disagreement needed to flip the debounced state (>=2).
- TICK_DIV, 50000, clk cycles per hold tick (1 ms at 50 MHz; >=2).
- LONG_TICKS, 800, ticks held in PRESSED before long_o fires (>=1).
- REPEAT_TICKS, 100, ticks between repeat_o pulses in HELD; 0 disables repeat.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pb_i  in  N_CH  raw asynchronous button pins.
- level_o  out  N_CH  debounced pressed level, 1 = pressed.
- press_o  out  N_CH  1-cycle pulse on debounced press.
- release_o  out  N_CH  1-cycle pulse on debounced release.
- long_o  out  N_CH  1-cycle pulse when the hold reaches LONG_TICKS.
- repeat_o  out  N_CH  1-cycle pulse every REPEAT_TICKS while in HELD.

Behaviour:
- Reset is rst_n, asynchronous, active-low, on clock clk.
- Reset values:
  - Sync flops load the inactive pin level (1 if ACTIVE_LOW).
  - All counters are 0.
  - FSM is RELEASED.
  - All outputs are 0.
- Normalise: p = pb_i XOR ACTIVE_LOW, so that 1 means pressed.
- Synchronise: sync0 <= p; sync1 <= sync0.
- Debounce counter, width $clog2(DEB_CYCLES):
  - While sync1 == level, the counter is cleared.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEB_CYCLES-1, level flips and the counter clears.
  - Any agreeing cycle before that clears the counter, so glitches shorter than DEB_CYCLES are fully rejected.
- Latency: after a clean step on pb_i, level_o changes exactly DEB_CYCLES+2 clk edges after the first edge that samples the new value.
- press_o and release_o are registered. Each is high for exactly the one cycle in which level_o first shows the new value.
- Tick prescaler:
  - Free-running, shared by all channels, counts 0..TICK_DIV-1.
  - tick is high for one cycle when the count is TICK_DIV-1.
  - It is not restarted on a press, so a long press fires between (LONG_TICKS-1)*TICK_DIV and LONG_TICKS*TICK_DIV cycles after the press. This one-tick jitter is accepted.
- Per-channel FSM (enum RELEASED, PRESSED, HELD) with a hold counter of width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1):
  - RELEASED: hold counter is 0. Debounced press -> PRESSED.
  - PRESSED: hold counter increments on tick. On the tick where the count reaches LONG_TICKS, pulse long_o, clear the counter and go to HELD.
  - HELD: if REPEAT_TICKS>0, the counter increments on tick; on reaching REPEAT_TICKS, pulse repeat_o and clear the counter. If REPEAT_TICKS==0, stay in HELD with no pulses.
  - Debounced release from any state -> RELEASED and clear the counter. Release takes priority over a coincident long/repeat event: that event's pulse is suppressed and only release_o fires.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- There is no combinational path from pb_i to any output. All outputs come from flops.
- Reset asserted mid-operation returns every channel to RELEASED immediately, with no release_o pulse.

Decomposition:
- Package multi_debounce_pkg:
  - btn_state_e enum (RELEASED, PRESSED, HELD).
  - clog2-based width localparam helper functions.
- Sub-module debounce_ch:
  - Contains one channel's synchroniser, debounce counter and FSM.
  - Takes tick as an input.
  - Instanced N_CH times by a generate loop.
- The top level holds only the prescaler and the generate loop.

Test Plan:
Test parameters: N_CH=4, ACTIVE_LOW=1, DEB_CYCLES=8, TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2.
- Clean press: drive pb_i[0] 1->0 and hold -> level_o[0]=1 and press_o[0]=1 for one cycle exactly 10 edges later; other channels stay 0.
- Bounce rejection: 5-cycle low pulses separated by 1-cycle highs on ch1 -> no level_o or press_o change; then a stable low produces a press 10 edges after the final bounce.
- Long press and repeat: hold ch2 low for 60 cycles -> one long_o pulse within 8..12 cycles after press_o, then repeat_o pulses exactly 8 cycles apart; release -> release_o, and repeats stop.
- Release coincident with a repeat tick on ch3 -> release_o only; repeat_o suppressed; FSM returns to RELEASED.
- All 4 channels pressed on the same cycle -> press_o = 4'hF in a single cycle.
- Reset: assert rst_n=0 in HELD mid-repeat -> all outputs 0 asynchronously; after deassert with pins still low, a fresh press_o appears 10 edges later.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// Shared types and width helpers for the multi-channel button conditioner.
package multi_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_e;

  // Counter width for a counter that runs 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Hold counter must represent the larger of the long-press and repeat periods.
  function automatic int hold_width(input int long_ticks, input int repeat_ticks);
    int m;
    m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF synchroniser, counter debounce and press/long/repeat FSM.
module debounce_ch
  import multi_debounce_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEB_CYCLES   = 65536,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int HW = hold_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  logic          pressed_now;
  logic          rise;
  logic          fall;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sync0_d     = pb_i;
    sync1_d     = sync0_q;
    // Normalise after synchronising so the sync flops carry the raw pin level.
    pressed_now = sync1_q ^ ACTIVE_LOW;

    deb_cnt_d = '0;
    level_d   = level_q;
    if (pressed_now != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = pressed_now;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    rise      = level_d & ~level_q;
    fall      = ~level_d & level_q;
    press_d   = rise;
    release_d = fall;

    state_d  = state_q;
    hold_d   = hold_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    // Release wins over a coincident long/repeat event, suppressing its pulse.
    if (fall) begin
      state_d = RELEASED;
      hold_d  = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          hold_d = '0;
          if (rise) state_d = PRESSED;
        end
        PRESSED: begin
          if (tick_i) begin
            if (hold_q == LONG_LAST) begin
              long_d  = 1'b1;
              hold_d  = '0;
              state_d = HELD;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        HELD: begin
          if ((REPEAT_TICKS > 0) && tick_i) begin
            if (hold_q == REPEAT_LAST) begin
              repeat_d = 1'b1;
              hold_d   = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = RELEASED;
          hold_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q   <= ACTIVE_LOW;
      sync1_q   <= ACTIVE_LOW;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      state_q   <= RELEASED;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/multi_debounce.sv
// N-channel button conditioner: shared hold-tick prescaler plus one debounce_ch per pin.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEB_CYCLES   = 65536,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] div_q, div_d;
  logic          tick;

  // Free-running and never restarted by a press; the one-tick jitter is accepted.
  always_comb begin
    tick  = (div_q == TICK_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .pb_i     (pb_i[g]),
      .tick_i   (tick),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule
